// File: rtl/instruction_loader.sv
// Instruction memory loader: packs a received byte stream into words (MSB first)
// and writes them to instruction memory starting at address 0. Write enable
// stays high for the entire load, which holds the fetch stage in write mode.
module instruction_loader #(
    parameter int SIZE            = 32,
    parameter int MAX_INSTRUCTION = 64,
    parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                  i_clk_write,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_words,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [SIZE-1:0]       o_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_words_loaded
);

    localparam int BYTES_PER_WORD = SIZE / 8;
    localparam int BYTE_IDX_WIDTH = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int COUNT_WIDTH    = ADDR_WIDTH + 1;
    localparam int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BYTE_IDX_WIDTH-1:0] LAST_BYTE    = BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [COUNT_WIDTH-1:0]    MAX_COUNT    = COUNT_WIDTH'(MAX_INSTRUCTION);
    localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    // Datapath registers. The committed-word count doubles as the word index:
    // both are cleared together on an accepted start and advance together.
    logic [BYTE_IDX_WIDTH-1:0] byte_idx;
    logic [COUNT_WIDTH-1:0]    words_committed;
    logic [COUNT_WIDTH-1:0]    count_latched;
    logic [SIZE-1:0]           buffer;
    logic [TIMEOUT_WIDTH-1:0]  timeout_cnt;
    logic [ADDR_WIDTH-1:0]     write_addr;
    logic [SIZE-1:0]           write_data;
    logic                      done;
    logic                      error;

    // Decoded control strobes from the next-state logic
    logic start_empty;
    logic start_bad;
    logic start_accept;
    logic byte_in;
    logic word_complete;
    logic timeout_hit;

    logic [SIZE-1:0]        word_assembled;
    logic [COUNT_WIDTH-1:0] words_next;

    assign word_assembled = (buffer << 8) | SIZE'(i_rx_data);
    assign words_next     = words_committed + COUNT_WIDTH'(1);

    // State register; reset abandons any load and drops enable immediately
    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and control strobes
    always_comb begin
        state_next    = state;
        start_empty   = 1'b0;
        start_bad     = 1'b0;
        start_accept  = 1'b0;
        byte_in       = 1'b0;
        word_complete = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_num_words == '0) begin
                        start_empty = 1'b1;
                    end else if (i_num_words > MAX_COUNT) begin
                        start_bad = 1'b1;
                    end else begin
                        start_accept = 1'b1;
                        state_next   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    byte_in = 1'b1;
                    if (byte_idx == LAST_BYTE) begin
                        word_complete = 1'b1;
                        if (words_next == count_latched) begin
                            state_next = ST_FLUSH;
                        end
                    end
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Byte packing, word commit, timeout counting and status flags
    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            byte_idx        <= '0;
            words_committed <= '0;
            count_latched   <= '0;
            buffer          <= '0;
            timeout_cnt     <= '0;
            write_addr      <= '0;
            write_data      <= '0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start_empty) begin
                done  <= 1'b1;
                error <= 1'b0;
            end

            if (start_bad) begin
                error <= 1'b1;
            end

            if (start_accept) begin
                error           <= 1'b0;
                words_committed <= '0;
                byte_idx        <= '0;
                buffer          <= '0;
                timeout_cnt     <= '0;
                count_latched   <= i_num_words;
                write_addr      <= '0;
                write_data      <= '0;
            end

            if (state == ST_LOAD) begin
                if (byte_in) begin
                    buffer      <= word_assembled;
                    byte_idx    <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + BYTE_IDX_WIDTH'(1);
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + TIMEOUT_WIDTH'(1);
                end

                if (word_complete) begin
                    write_addr      <= words_committed[ADDR_WIDTH-1:0];
                    write_data      <= word_assembled;
                    words_committed <= words_next;
                end

                if (timeout_hit) begin
                    error       <= 1'b1;
                    write_addr  <= '0;
                    write_data  <= '0;
                    buffer      <= '0;
                    byte_idx    <= '0;
                    timeout_cnt <= '0;
                end
            end

            if (state == ST_FLUSH) begin
                done        <= 1'b1;
                write_addr  <= '0;
                write_data  <= '0;
                buffer      <= '0;
                byte_idx    <= '0;
                timeout_cnt <= '0;
            end
        end
    end

    assign o_inst_write_enable = (state != ST_IDLE);
    assign o_busy              = (state != ST_IDLE);
    assign o_write_addr        = write_addr;
    assign o_write_data        = write_data;
    assign o_done              = done;
    assign o_error             = error;
    assign o_words_loaded      = words_committed;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: random byte streams are packed by
// a simple arithmetic reference and compared against a behavioural instruction
// memory that captures every write the loader issues.
module tb_instruction_loader;

    localparam int SIZE            = 32;
    localparam int MAX_INSTRUCTION = 64;
    localparam int ADDR_WIDTH      = 6;
    localparam int TIMEOUT_CYCLES  = 16;
    localparam int NW              = ADDR_WIDTH + 1;

    logic                  i_clk_write = 1'b0;
    logic                  i_rst;
    logic                  i_start;
    logic [NW-1:0]         i_num_words;
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_inst_write_enable;
    logic [ADDR_WIDTH-1:0] o_write_addr;
    logic [SIZE-1:0]       o_write_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [NW-1:0]         o_words_loaded;

    instruction_loader #(
        .SIZE(SIZE),
        .MAX_INSTRUCTION(MAX_INSTRUCTION),
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk_write(i_clk_write),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_num_words(i_num_words),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_inst_write_enable(o_inst_write_enable),
        .o_write_addr(o_write_addr),
        .o_write_data(o_write_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error),
        .o_words_loaded(o_words_loaded)
    );

    always #5 i_clk_write = ~i_clk_write;

    int checks   = 0;
    int failures = 0;

    // Behavioural instruction memory: captures whatever the loader drives while enabled
    logic [SIZE-1:0] mem_model [MAX_INSTRUCTION];
    int write_count = 0;
    always @(posedge i_clk_write) begin
        if (o_inst_write_enable) begin
            mem_model[o_write_addr] <= o_write_data;
            write_count <= write_count + 1;
        end
    end

    logic [SIZE-1:0] exp_words [MAX_INSTRUCTION];
    logic [7:0]      byte_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk_write);
        #1;
    endtask

    function automatic logic [7:0] nextByte();
        if (byte_q.size() > 0) return byte_q.pop_front();
        return 8'($urandom);
    endfunction

    task automatic applyStimulus(input int num_words);
        i_start     = 1'b1;
        i_num_words = NW'(num_words);
        tick();
        i_start     = 1'b0;
        i_num_words = NW'($urandom);
    endtask

    task automatic sendByte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic idleCycles(input int n, input logic expect_en);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput("enable_hold", 32'(o_inst_write_enable), 32'(expect_en));
        end
    endtask

    // Complete load of n words with random idle gaps; optionally pokes i_start mid-load
    task automatic runLoad(input int n, input int max_gap, input bit poke_start);
        logic [SIZE-1:0] word;
        logic [7:0]      b;
        applyStimulus(n);
        checkOutput("enable_after_start", 32'(o_inst_write_enable), 32'd1);
        checkOutput("busy_after_start", 32'(o_busy), 32'd1);
        checkOutput("error_cleared", 32'(o_error), 32'd0);
        checkOutput("words_cleared", 32'(o_words_loaded), 32'd0);
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int k = 0; k < SIZE / 8; k++) begin
                idleCycles((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, 1'b1);
                if (poke_start && w == 0 && k == 2) begin
                    i_start     = 1'b1;
                    i_num_words = NW'(5);
                    tick();
                    i_start     = 1'b0;
                    checkOutput("start_ignored_busy", 32'(o_busy), 32'd1);
                end
                b    = nextByte();
                word = (word * 256) + 32'(b);
                sendByte(b);
            end
            exp_words[w] = word;
            checkOutput("commit_addr", 32'(o_write_addr), 32'(w));
            checkOutput("commit_data", o_write_data, word);
            checkOutput("commit_count", 32'(o_words_loaded), 32'(w + 1));
        end
        checkOutput("flush_enable", 32'(o_inst_write_enable), 32'd1);
        checkOutput("flush_done_low", 32'(o_done), 32'd0);
        tick();
        checkOutput("done_pulse", 32'(o_done), 32'd1);
        checkOutput("enable_off_with_done", 32'(o_inst_write_enable), 32'd0);
        checkOutput("busy_off", 32'(o_busy), 32'd0);
        checkOutput("idle_addr", 32'(o_write_addr), 32'd0);
        checkOutput("idle_data", o_write_data, 32'd0);
        checkOutput("words_loaded", 32'(o_words_loaded), 32'(n));
        tick();
        checkOutput("done_single_cycle", 32'(o_done), 32'd0);
        for (int i = 0; i < n; i++) begin
            checkOutput("mem_word", mem_model[i], exp_words[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SIZE-1:0] word0;
        logic [7:0]      b;
        int              wc;

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_num_words = '0;
        i_rx_data   = '0;
        i_rx_valid  = 1'b0;
        #12;
        checkOutput("rst_enable", 32'(o_inst_write_enable), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_addr", 32'(o_write_addr), 32'd0);
        checkOutput("rst_data", o_write_data, 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_error", 32'(o_error), 32'd0);
        checkOutput("rst_words", 32'(o_words_loaded), 32'd0);
        tick();
        i_rst = 1'b0;
        tick();

        $display("[TB] reset during a load");
        applyStimulus(2);
        sendByte(8'hde);
        sendByte(8'had);
        sendByte(8'hbe);
        sendByte(8'hef);
        sendByte(8'h11);
        checkOutput("preRst_data", o_write_data, 32'hdeadbeef);
        #1;
        i_rst = 1'b1;
        #1;
        checkOutput("midRst_enable", 32'(o_inst_write_enable), 32'd0);
        checkOutput("midRst_busy", 32'(o_busy), 32'd0);
        checkOutput("midRst_addr", 32'(o_write_addr), 32'd0);
        checkOutput("midRst_data", o_write_data, 32'd0);
        checkOutput("midRst_words", 32'(o_words_loaded), 32'd0);
        tick();
        i_rst = 1'b0;
        tick();

        $display("[TB] single word");
        byte_q = '{8'h20, 8'h01, 8'h00, 8'h05};
        runLoad(1, 0, 1'b0);
        checkOutput("single_word_mem", mem_model[0], 32'h20010005);

        $display("[TB] three words with gaps");
        runLoad(3, 12, 1'b0);

        $display("[TB] timeout");
        applyStimulus(2);
        word0 = '0;
        for (int k = 0; k < 6; k++) begin
            b = nextByte();
            if (k < 4) word0 = (word0 * 256) + 32'(b);
            sendByte(b);
            if (k == 3) begin
                checkOutput("to_commit_data", o_write_data, word0);
            end
        end
        idleCycles(TIMEOUT_CYCLES - 1, 1'b1);
        checkOutput("to_error_pending", 32'(o_error), 32'd0);
        tick();
        checkOutput("to_error", 32'(o_error), 32'd1);
        checkOutput("to_enable", 32'(o_inst_write_enable), 32'd0);
        checkOutput("to_busy", 32'(o_busy), 32'd0);
        checkOutput("to_words", 32'(o_words_loaded), 32'd1);
        checkOutput("to_addr", 32'(o_write_addr), 32'd0);
        checkOutput("to_done", 32'(o_done), 32'd0);
        checkOutput("to_mem0", mem_model[0], word0);
        runLoad(1, 3, 1'b0);

        $display("[TB] bad counts");
        applyStimulus(MAX_INSTRUCTION + 1);
        checkOutput("over_error", 32'(o_error), 32'd1);
        checkOutput("over_enable", 32'(o_inst_write_enable), 32'd0);
        checkOutput("over_done", 32'(o_done), 32'd0);
        idleCycles(3, 1'b0);
        applyStimulus(0);
        checkOutput("zero_done", 32'(o_done), 32'd1);
        checkOutput("zero_error_cleared", 32'(o_error), 32'd0);
        checkOutput("zero_enable", 32'(o_inst_write_enable), 32'd0);
        tick();
        checkOutput("zero_done_end", 32'(o_done), 32'd0);
        checkOutput("zero_enable_end", 32'(o_inst_write_enable), 32'd0);

        $display("[TB] ignored inputs");
        wc = write_count;
        for (int k = 0; k < 6; k++) begin
            sendByte(8'($urandom));
            checkOutput("idle_byte_enable", 32'(o_inst_write_enable), 32'd0);
        end
        checkOutput("idle_byte_writes", 32'(write_count), 32'(wc));
        checkOutput("idle_byte_words", 32'(o_words_loaded), 32'd1);
        runLoad(2, 4, 1'b1);

        $display("[TB] full depth");
        runLoad(MAX_INSTRUCTION, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
